// File: rtl/mlp_loader_pkg.sv
// Shared constants, opcodes and FSM state encoding for the MLP host loader.
// Optional feature macro: MLP_LOADER_CHKSUM_EN (adds the trailing XOR checksum byte).
package mlp_loader_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] OP_INPUT  = 8'h01;
  localparam logic [DATA_W-1:0] OP_WEIGHT = 8'h02;
  localparam logic [DATA_W-1:0] OP_BIAS   = 8'h03;
  localparam logic [DATA_W-1:0] OP_START  = 8'h10;

  typedef enum logic [3:0] {
    IDLE,
    HDR_A0,
    HDR_A1,
    HDR_L0,
    HDR_L1,
    DATA,
    START,
    WAIT_DONE
`ifdef MLP_LOADER_CHKSUM_EN
    , CHK
`endif
  } state_t;

  typedef enum logic [1:0] {
    SEL_INPUT,
    SEL_WEIGHT,
    SEL_BIAS
  } sel_t;

  // One BRAM write beat, shared by all three write ports
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/mlp_host_loader.sv
// Host byte-stream frame parser that loads input/weight/bias BRAMs and
// kicks the MLP accelerator. Optional macro: MLP_LOADER_CHKSUM_EN.
module mlp_host_loader
  import mlp_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] input_addr,
  output logic [DATA_W-1:0] input_data,
  output logic              input_we,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [DATA_W-1:0] weight_data,
  output logic              weight_we,
  output logic [ADDR_W-1:0] bias_addr,
  output logic [DATA_W-1:0] bias_data,
  output logic              bias_we,
  output logic              start_out,
  input  logic              busy_in,
  input  logic              done_in,
  output logic              frame_done,
  output logic              err,
  output logic              loader_busy
);

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  wr_beat_t          beat_q, beat_d;
  logic [2:0]        we_q, we_d;
  logic              start_q, start_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              accept;
`ifdef MLP_LOADER_CHKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
`endif

  assign accept = s_valid && rdy_q;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    beat_d     = beat_q;
    we_d       = 3'b000;
    start_d    = 1'b0;
    fd_d       = 1'b0;
    err_d      = 1'b0;
`ifdef MLP_LOADER_CHKSUM_EN
    chk_d      = chk_q;
    if (accept) begin
      chk_d = (state_q == IDLE) ? s_data : (chk_q ^ s_data);
    end
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (s_data)
            OP_INPUT:  begin sel_d = SEL_INPUT;  state_d = HDR_A0; end
            OP_WEIGHT: begin sel_d = SEL_WEIGHT; state_d = HDR_A0; end
            OP_BIAS:   begin sel_d = SEL_BIAS;   state_d = HDR_A0; end
            OP_START:  begin start_d = 1'b1;     state_d = START;  end
            default:   err_d = 1'b1;
          endcase
        end
      end
      HDR_A0: begin
        if (accept) begin
          cur_addr_d[7:0] = s_data;
          state_d         = HDR_A1;
        end
      end
      HDR_A1: begin
        if (accept) begin
          cur_addr_d[15:8] = s_data;
          state_d          = HDR_L0;
        end
      end
      HDR_L0: begin
        if (accept) begin
          rem_d[7:0] = s_data;
          state_d    = HDR_L1;
        end
      end
      HDR_L1: begin
        if (accept) begin
          rem_d[15:8] = s_data;
          if ({s_data, rem_q[7:0]} == 16'd0) begin
`ifdef MLP_LOADER_CHKSUM_EN
            state_d = CHK;
`else
            fd_d    = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          beat_d.addr = cur_addr_q;
          beat_d.data = s_data;
          case (sel_q)
            SEL_INPUT:  we_d = 3'b001;
            SEL_WEIGHT: we_d = 3'b010;
            default:    we_d = 3'b100;
          endcase
          cur_addr_d = cur_addr_q + 16'd1;
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef MLP_LOADER_CHKSUM_EN
            state_d = CHK;
`else
            fd_d    = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_in) begin
          fd_d    = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef MLP_LOADER_CHKSUM_EN
      CHK: begin
        if (accept) begin
          if (s_data == chk_q) fd_d  = 1'b1;
          else                 err_d = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Ready tracks the state being entered; IDLE also backs off while the accelerator is busy
    case (state_d)
      START, WAIT_DONE: rdy_d = 1'b0;
      IDLE:             rdy_d = !busy_in;
      default:          rdy_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= SEL_INPUT;
      cur_addr_q <= '0;
      rem_q      <= '0;
      beat_q     <= '0;
      we_q       <= 3'b000;
      start_q    <= 1'b0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MLP_LOADER_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      beat_q     <= beat_d;
      we_q       <= we_d;
      start_q    <= start_d;
      fd_q       <= fd_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
`ifdef MLP_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Shared beat register fanned out to all three BRAM ports
  assign input_addr  = beat_q.addr;
  assign input_data  = beat_q.data;
  assign input_we    = we_q[0];
  assign weight_addr = beat_q.addr;
  assign weight_data = beat_q.data;
  assign weight_we   = we_q[1];
  assign bias_addr   = beat_q.addr;
  assign bias_data   = beat_q.data;
  assign bias_we     = we_q[2];
  assign start_out   = start_q;
  assign frame_done  = fd_q;
  assign err         = err_q;
  assign s_ready     = rdy_q;
  assign loader_busy = busy_q;

endmodule

// File: tb/tb_mlp_host_loader.sv
// Self-checking bench for mlp_host_loader; write beats are scoreboarded.
module tb_mlp_host_loader;

`ifdef MLP_LOADER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] input_addr, weight_addr, bias_addr;
  logic [7:0]  input_data, weight_data, bias_data;
  logic        input_we, weight_we, bias_we;
  logic        start_out, busy_in, done_in, frame_done, err, loader_busy;

  mlp_host_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .input_addr(input_addr), .input_data(input_data), .input_we(input_we),
    .weight_addr(weight_addr), .weight_data(weight_data), .weight_we(weight_we),
    .bias_addr(bias_addr), .bias_data(bias_data), .bias_we(bias_we),
    .start_out(start_out), .busy_in(busy_in), .done_in(done_in),
    .frame_done(frame_done), .err(err), .loader_busy(loader_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;

  exp_t        mon_e;
  int          mon_port;
  int          mon_nwe;
  logic [15:0] mon_addr;
  logic [7:0]  mon_data;

  // Write monitor: every we beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done) fd_cnt++;
      if (err) err_cnt++;
      if (start_out) start_cnt++;
      if (input_we || weight_we || bias_we) begin
        mon_nwe  = int'(input_we) + int'(weight_we) + int'(bias_we);
        mon_port = input_we ? 0 : (weight_we ? 1 : 2);
        mon_addr = input_we ? input_addr : (weight_we ? weight_addr : bias_addr);
        mon_data = input_we ? input_data : (weight_we ? weight_data : bias_data);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected port=%0d addr=%h data=%h required no write", mon_port, mon_addr, mon_data);
        end else begin
          mon_e = sb.pop_front();
          if (mon_port !== mon_e.port || mon_addr !== mon_e.addr || mon_data !== mon_e.data ||
              frame_done !== mon_e.last || mon_nwe != 1) begin
            bad++;
            $display("FAIL write_beat got port=%0d addr=%h data=%h fd=%b nwe=%0d required port=%0d addr=%h data=%h fd=%b nwe=1",
                     mon_port, mon_addr, mon_data, frame_done, mon_nwe, mon_e.port, mon_e.addr, mon_e.data, mon_e.last);
          end
        end
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout byte=%h s_ready=%b required 1", b, s_ready);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic send_write(input logic [7:0] op, input logic [15:0] base,
                            input logic [7:0] pl[$], input bit corrupt);
    logic [7:0]  x;
    logic [15:0] len;
    len = 16'(pl.size());
    x = op ^ base[7:0] ^ base[15:8] ^ len[7:0] ^ len[15:8];
    send_byte(op);
    send_byte(base[7:0]);
    send_byte(base[15:8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < pl.size(); i++) begin
      sb.push_back('{int'(op) - 1, base + 16'(i), pl[i], !CHK && (i == pl.size() - 1)});
      x = x ^ pl[i];
      send_byte(pl[i]);
    end
    if (CHK) send_byte(corrupt ? 8'h00 : x);
  endtask

  task automatic check_all_zero(input string name);
    logic [79:0] v;
    v = {s_ready, input_we, weight_we, bias_we, input_addr, input_data, weight_addr, weight_data,
         bias_addr, bias_data, start_out, frame_done, err, loader_busy};
    total++;
    if (v !== 80'd0) begin
      bad++;
      $display("FAIL %s outputs=%h required 0", name, v);
    end
  endtask

  task automatic test_reset;
    #12;
    check_all_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;
    settle(2);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required 1", s_ready); end
    total++;
    if (loader_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required 0", loader_busy); end
  endtask

  task automatic test_input_write;
    int f0, e0;
    f0 = fd_cnt; e0 = err_cnt;
    send_write(8'h01, 16'h0010, '{8'hAA, 8'hBB, 8'hCC}, 1'b0);
    settle(3);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL input_pending got=%0d required 0", sb.size()); end
    total++;
    if (fd_cnt != f0 + 1) begin bad++; $display("FAIL input_frame_done got=%0d required %0d", fd_cnt - f0, 1); end
    total++;
    if (err_cnt != e0) begin bad++; $display("FAIL input_err got=%0d required 0", err_cnt - e0); end
  endtask

  task automatic test_wrap_backpressure;
    int f0;
    logic [7:0] hdr[5];
    logic [7:0] pl[2];
    hdr = '{8'h02, 8'hFF, 8'hFF, 8'h02, 8'h00};
    pl  = '{8'h11, 8'h22};
    f0 = fd_cnt;
    foreach (hdr[i]) begin
      send_byte(hdr[i]);
      repeat (3) @(negedge clk);
    end
    sb.push_back('{1, 16'hFFFF, 8'h11, 1'b0});
    sb.push_back('{1, 16'h0000, 8'h22, !CHK});
    foreach (pl[i]) begin
      send_byte(pl[i]);
      repeat (3) @(negedge clk);
    end
    if (CHK) send_byte(8'h02 ^ 8'hFF ^ 8'hFF ^ 8'h02 ^ 8'h11 ^ 8'h22);
    settle(3);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL wrap_pending got=%0d required 0", sb.size()); end
    total++;
    if (fd_cnt != f0 + 1) begin bad++; $display("FAIL wrap_frame_done got=%0d required 1", fd_cnt - f0); end
    total++;
    if (weight_addr !== 16'h0000 || weight_data !== 8'h22) begin
      bad++;
      $display("FAIL wrap_hold got=%h/%h required 0000/22", weight_addr, weight_data);
    end
  endtask

  task automatic test_start;
    int s0, f0, n, rdy_bad;
    s0 = start_cnt; f0 = fd_cnt;
    send_byte(8'h10);
    n = 0;
    @(negedge clk);
    while (!start_out && n < 20) begin @(negedge clk); n++; end
    total++;
    if (start_out !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b required 1", start_out); end
    rdy_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || frame_done !== 1'b0) rdy_bad++;
    end
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    #1;
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL start_frame_done got=%b required 1", frame_done); end
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL start_ready_low got=%0d bad cycles required 0", rdy_bad); end
    settle(3);
    total++;
    if (start_cnt != s0 + 1) begin bad++; $display("FAIL start_count got=%0d required 1", start_cnt - s0); end
    total++;
    if (fd_cnt != f0 + 1) begin bad++; $display("FAIL start_fd_count got=%0d required 1", fd_cnt - f0); end
  endtask

  task automatic test_idle_inputs;
    int f0;
    f0 = fd_cnt;
    @(negedge clk) done_in = 1'b1;
    settle(2);
    done_in = 1'b0;
    settle(2);
    total++;
    if (fd_cnt != f0) begin bad++; $display("FAIL done_ignored got=%0d required 0", fd_cnt - f0); end
    busy_in = 1'b1;
    settle(2);
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b required 0", s_ready); end
    busy_in = 1'b0;
    settle(2);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL busy_release got=%b required 1", s_ready); end
  endtask

  task automatic test_bad_opcode;
    int e0, f0;
    e0 = err_cnt; f0 = fd_cnt;
    send_byte(8'h7E);
    settle(2);
    total++;
    if (err_cnt != e0 + 1) begin bad++; $display("FAIL bad_op_err got=%0d required 1", err_cnt - e0); end
    send_write(8'h03, 16'h0000, '{8'h5A}, 1'b0);
    settle(3);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL bad_op_pending got=%0d required 0", sb.size()); end
    total++;
    if (fd_cnt != f0 + 1 || err_cnt != e0 + 1) begin
      bad++;
      $display("FAIL bad_op_follow fd=%0d err=%0d required fd=1 err=1", fd_cnt - f0, err_cnt - e0);
    end
  endtask

  task automatic test_len_zero;
    int f0;
    f0 = fd_cnt;
    send_write(8'h01, 16'h1234, '{}, 1'b0);
    settle(3);
    total++;
    if (fd_cnt != f0 + 1) begin bad++; $display("FAIL len0_frame_done got=%0d required 1", fd_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int f0;
    logic [7:0] hdr[5];
    hdr = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h00};
    foreach (hdr[i]) send_byte(hdr[i]);
    sb.push_back('{0, 16'h0000, 8'hD1, 1'b0});
    sb.push_back('{0, 16'h0001, 8'hD2, 1'b0});
    send_byte(8'hD1);
    send_byte(8'hD2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle(2);
    f0 = fd_cnt;
    send_write(8'h03, 16'h0040, '{8'h77}, 1'b0);
    settle(3);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_mid_pending got=%0d required 0", sb.size()); end
    total++;
    if (fd_cnt != f0 + 1) begin bad++; $display("FAIL reset_mid_frame got=%0d required 1", fd_cnt - f0); end
  endtask

`ifdef MLP_LOADER_CHKSUM_EN
  task automatic test_checksum;
    int f0, e0;
    f0 = fd_cnt; e0 = err_cnt;
    send_write(8'h01, 16'h0000, '{8'h55}, 1'b0);
    settle(3);
    total++;
    if (fd_cnt != f0 + 1 || err_cnt != e0) begin
      bad++;
      $display("FAIL chk_good fd=%0d err=%0d required fd=1 err=0", fd_cnt - f0, err_cnt - e0);
    end
    send_write(8'h01, 16'h0000, '{8'h55}, 1'b1);
    settle(3);
    total++;
    if (fd_cnt != f0 + 1 || err_cnt != e0 + 1) begin
      bad++;
      $display("FAIL chk_bad fd=%0d err=%0d required fd=1 err=1", fd_cnt - f0, err_cnt - e0);
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL chk_pending got=%0d required 0", sb.size()); end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    busy_in = 1'b0;
    done_in = 1'b0;
    test_reset;
    test_input_write;
    test_wrap_backpressure;
    test_start;
    test_idle_inputs;
    test_bad_opcode;
    test_len_zero;
    test_reset_mid;
`ifdef MLP_LOADER_CHKSUM_EN
    test_checksum;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_host_loader.md
MLP_HOST_LOADER -- requirements
Module: mlp_host_loader

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  host command/payload byte stream
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted when s_valid && s_ready
- input_addr / input_data / input_we  out  16/8/1  input-BRAM write port of the accelerator
- weight_addr / weight_data / weight_we  out  16/8/1  weight-BRAM write port
- bias_addr / bias_data / bias_we  out  16/8/1  bias-BRAM write port
- start_out  out  1  accelerator start pulse
- busy_in  in  1  accelerator busy
- done_in  in  1  accelerator done
- frame_done  out  1  one-cycle pulse at the end of each completed frame
- err  out  1  one-cycle pulse on a frame error
- loader_busy  out  1  high whenever the FSM is not in IDLE

Function
REQ-003 SHALL parse frames with this layout:
- opcode byte
- for write opcodes only: addr_lo, addr_hi, len_lo, len_hi, then len payload bytes
- all multi-byte fields little-endian
REQ-004 SHALL use these opcodes: 0x01 input write, 0x02 weight write, 0x03 bias write, 0x10 start.
REQ-005 SHALL implement FSM states IDLE, HDR_A0, HDR_A1, HDR_L0, HDR_L1, DATA, START, WAIT_DONE; each state advances only on an accepted byte, except START and WAIT_DONE.
REQ-006 SHALL drive s_ready high in all states except START and WAIT_DONE, and except IDLE while busy_in=1.
REQ-007 SHALL, on accepting payload byte k (k=0..len-1), drive on the next cycle the selected port with:
- addr = (base + k) mod 2^16
- data = the byte
- we = 1 for exactly one cycle
- the other two ports' we = 0
REQ-008 SHALL hold addr/data registered and unchanged between writes; we is low except on write cycles.
REQ-009 SHALL, for len=0, issue no writes and pulse frame_done in the cycle after len_hi is accepted, returning to IDLE.
REQ-010 SHALL pulse frame_done in the same cycle as the we of the last payload byte, returning to IDLE.
REQ-011 SHALL, for an unknown opcode, pulse err in the cycle after acceptance, issue no writes, and remain in IDLE (only the opcode byte is consumed).
REQ-012 SHALL, for opcode 0x10, execute the start sequence:
- enter START and pulse start_out for one cycle
- then enter WAIT_DONE
- on done_in=1 in WAIT_DONE, pulse frame_done the next cycle and return to IDLE
REQ-013 SHALL ignore done_in outside WAIT_DONE.
REQ-014 SHALL let base-address wrap past 0xFFFF to 0x0000 without error.

Reset
REQ-015 SHALL, on rst_n=0 at any time (including mid-frame), immediately reset to this state:
- FSM in IDLE
- all outputs 0 (s_ready, every *_we, addr, data, start_out, frame_done, err, loader_busy)
- counters cleared
REQ-016 SHALL discard any partial frame on reset.
REQ-017 SHALL expect the next byte after reset release to be an opcode.

Configuration
REQ-018 SHALL support macro MLP_LOADER_CHKSUM_EN.
REQ-019 SHALL, when MLP_LOADER_CHKSUM_EN is defined, apply the checksum to write frames as follows:
- one extra checksum byte follows the payload (or follows len_hi when len=0)
- the checksum equals the XOR of all preceding frame bytes including the opcode
- the frame ends on the checksum byte: frame_done on match, err on mismatch, pulsed the cycle after acceptance
- writes already issued are not undone
- start frames carry no checksum
REQ-020 SHALL, when MLP_LOADER_CHKSUM_EN is not defined, include no checksum byte, logic or state.

Structure
REQ-021 SHALL place the opcode constants, the FSM state enum and the address/length widths (16) in package mlp_loader_pkg.
REQ-022 SHALL be a single module with no sub-modules; the three write ports share one addr/data register set, fanned out.

Verification
REQ-023 SHALL cover input write: bytes 01 10 00 03 00 AA BB CC -> input_we pulses with addr 0x0010/AA, 0x0011/BB, 0x0012/CC; frame_done with the last write.
REQ-024 SHALL cover wrap and backpressure: 02 FF FF 02 00 11 22 with s_valid gapped -> weight writes 0xFFFF/11, 0x0000/22; no we in gap cycles.
REQ-025 SHALL cover start: 10, done_in raised 5 cycles after start_out -> one start_out pulse, s_ready=0 throughout, frame_done the cycle after done_in.
REQ-026 SHALL cover bad opcode: 7E then 03 00 00 01 00 5A -> err pulse, then bias write 0x0000/5A.
REQ-027 SHALL cover reset mid-frame: rst_n low after 2 of 4 payload bytes -> all outputs 0; a subsequent frame is parsed from its opcode.
REQ-028 SHALL cover checksum with MLP_LOADER_CHKSUM_EN defined: 01 00 00 01 00 55 55 -> frame_done; the same frame with last byte 00 -> err.
